// File: rtl/uart_ascii_tx.sv
// uart_ascii_tx: FIFO-buffered 8N1 UART transmitter for hex-ASCII output.
// Ports: clk, rst_n (async low); tx_data/tx_valid/tx_ready write side;
//   tx serial line (idle high); busy; fifo_count characters buffered.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit after data).
module uart_ascii_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV > 1 ? BAUD_DIV : 2);
  localparam logic [CW-1:0] DIV_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_tx_ready;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_shift;
  logic [2:0]    r_idx;
  logic          r_par;
  logic          r_tx;

  logic [AW:0]   w_count;
  logic [AW:0]   w_count_nxt;
  logic          w_empty;
  logic          w_bit_end;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_rd_data;

  // Extra pointer bit separates full from empty.
  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_count == '0);
  assign w_bit_end = (r_cnt == DIV_LAST);
  assign w_push    = tx_valid && r_tx_ready;
  // Pop when idle, or at the last stop-bit cycle for a gapless next frame.
  assign w_pop     = !w_empty &&
                     ((r_state == S_IDLE) ||
                      (r_state == S_STOP && w_bit_end));
  assign w_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_count_nxt = w_count
                     + {{AW{1'b0}}, w_push}
                     - {{AW{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_tx_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_tx_ready <= (w_count_nxt != DEPTH_C);
    end
  end

  // tx is set on each transition so it always holds the current bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= w_rd_data;
            r_par   <= ^w_rd_data;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_par;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_shift <= {1'b0, r_shift[7:1]};
              r_idx   <= r_idx + 3'd1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_shift <= w_rd_data;
              r_par   <= ^w_rd_data;
              r_idx   <= '0;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign tx_ready   = r_tx_ready;
  assign busy       = (r_state != S_IDLE) || !w_empty;
  assign fifo_count = w_count;

endmodule
